axis_sum_7seg_display: RTL and testbench

- Downstream sink for the AXI-stream running-sum stage (W-bit unsigned sum on m_data/m_valid/m_ready).
- Accepts one sum per handshake and converts it to BCD with a sequential double-dabble engine.
- Drives a D-digit, time-multiplexed, common-anode 7-segment display with active-low anodes and segments.
- Holds the last converted value on the display until the next sum is accepted.

---
 rtl/sevseg_pkg.sv | 30 +++
 rtl/bin2bcd_seq.sv | 52 +++++
 rtl/axis_sum_7seg_display.sv | 134 +++++++++++++
 tb/tb_axis_sum_7seg_display.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the AXI-stream sum to 7-segment display path.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package sevseg_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } fsm_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Decimal digits of 2^w-1 are floor(w*log10(2))+1 since 2^w is never a power of ten.
  function automatic int bcd_width(input int w);
    return 4 * (((w * 30103) / 100000) + 1);
  endfunction

  function automatic logic [6:0] seg_encode(input bcd_digit_t d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_LUT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: W-bit binary to D BCD nibbles, one bit per cycle.
// i_start is ignored while a conversion is in progress.
module bin2bcd_seq
  import sevseg_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_bin,
  output logic           o_busy,
  output logic           o_done,
  output logic [D*4-1:0] o_bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   r_bin;
  logic [D*4-1:0] r_bcd;
  logic [CW-1:0]  r_cnt;
  logic [D*4-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < D; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start && (r_cnt == '0)) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      {r_bcd, r_bin} <= {w_adj[D*4-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);
  // High during the final shift cycle, so o_bcd is complete on the following cycle.
  assign o_done = (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/axis_sum_7seg_display.sv
// AXI-stream sum sink: converts each accepted sum to BCD and scans it onto a
// common-anode 7-segment display. Optional macro: SEVSEG_LEADING_ZERO_BLANK_EN.
module axis_sum_7seg_display
  import sevseg_pkg::*;
#(
  parameter int W           = 16,
  parameter int D           = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic [D-1:0] an,
  output logic [6:0]   seg,
  output logic         upd
);

  localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIW = (D > 1) ? $clog2(D) : 1;

  if (D * 4 < bcd_width(W)) begin : g_width_chk
    $error("axis_sum_7seg_display: D too small to hold the BCD form of 2^W-1");
  end

  fsm_t           r_state;
  fsm_t           w_state_next;
  logic           r_s_ready;
  logic           r_upd;
  logic [D*4-1:0] r_disp;
  logic           w_start;
  logic           w_busy;
  logic           w_done;
  logic [D*4-1:0] w_bcd;

  bin2bcd_seq #(.W(W), .D(D)) u_bin2bcd (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_start),
    .i_bin   (s_data),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (s_valid && r_s_ready && !w_busy) begin
          w_start      = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV:    if (w_done) w_state_next = LOAD;
      LOAD:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b0;
      r_upd     <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_s_ready <= (w_state_next == IDLE);
      r_upd     <= (r_state == LOAD);
      if (r_state == LOAD) r_disp <= w_bcd;
    end
  end

  logic [RW-1:0]  r_refresh;
  logic [DIW-1:0] r_digit_idx;
  logic [D-1:0]   r_an;
  logic [6:0]     r_seg;
  logic [D-1:0]   w_an_next;
  logic [6:0]     w_seg_next;
  bcd_digit_t     w_cur_digit;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic [D-1:0] w_lz;

  // w_lz[i] marks digit i as a leading zero: it and every higher nibble are zero.
  always_comb begin
    logic v_run;
    w_lz  = '0;
    v_run = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      v_run   = v_run && (r_disp[i*4 +: 4] == 4'd0);
      w_lz[i] = v_run;
    end
  end
`endif

  always_comb begin
    w_an_next = '1;
    for (int i = 0; i < D; i++) w_an_next[i] = (int'(r_digit_idx) != i);
    w_cur_digit = r_disp[int'(r_digit_idx)*4 +: 4];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    w_seg_next = w_lz[r_digit_idx] ? SEG_BLANK : seg_encode(w_cur_digit);
`else
    w_seg_next = seg_encode(w_cur_digit);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh   <= '0;
      r_digit_idx <= '0;
      r_an        <= '1;
      r_seg       <= SEG_BLANK;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      if (r_refresh == RW'(REFRESH_DIV - 1)) begin
        r_refresh   <= '0;
        r_digit_idx <= (r_digit_idx == DIW'(D - 1)) ? '0 : r_digit_idx + DIW'(1);
      end else begin
        r_refresh <= r_refresh + RW'(1);
      end
    end
  end

  assign s_ready = r_s_ready;
  assign upd     = r_upd;
  assign an      = r_an;
  assign seg     = r_seg;

endmodule

// File: tb/tb_axis_sum_7seg_display.sv
// Bench for axis_sum_7seg_display: directed and random sums against a decimal
// display model; handshake timing, upd pulse and every scan slot are checked each cycle.
module tb_axis_sum_7seg_display;

  localparam int W = 16;
  localparam int D = 5;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic [D-1:0] an;
  logic [6:0]   seg;
  logic         upd;

  int n_total = 0;
  int n_bad   = 0;

  axis_sum_7seg_display #(.W(W), .D(D), .REFRESH_DIV(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .an      (an),
    .seg     (seg),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected pattern for decimal position `slot` of `val`.
  function automatic logic [6:0] exp_seg(input int unsigned val, input int slot);
    int unsigned p;
    int unsigned digit;
    p = 1;
    for (int i = 0; i < slot; i++) p = p * 10;
    digit = (val / p) % 10;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    if (slot > 0 && val < p) return 7'h7F;
`endif
    case (digit)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Scoreboard: accepted sums waiting to appear, with the edge at which they must.
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           acc_edges[$];
  int           edge_n = 0;
  int           scan_n = 0;
  int unsigned  m_disp = 0;
  int unsigned  m_prev = 0;
  logic         p_rst  = 1'b1;
  logic         p_acc  = 1'b0;
  logic [W-1:0] p_data = '0;

  always @(negedge clk) begin
    logic         upd_e;
    int           idx;
    logic [D-1:0] an_e;
    edge_n++;
    if (p_rst) begin
      exp_q.delete();
      due_q.delete();
      m_disp = 0;
      scan_n = 0;
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_upd", {31'd0, upd}, 32'd0);
      check("rst_an", {27'd0, an}, 32'h1F);
      check("rst_seg", {25'd0, seg}, 32'h7F);
    end else begin
      m_prev = m_disp;
      upd_e  = 1'b0;
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        m_disp = exp_q.pop_front();
        void'(due_q.pop_front());
        upd_e = 1'b1;
      end
      if (p_acc) begin
        exp_q.push_back(p_data);
        due_q.push_back(edge_n + W + 1);
        acc_edges.push_back(edge_n);
      end
      idx = (scan_n / R) % D;
      scan_n++;
      an_e      = '1;
      an_e[idx] = 1'b0;
      check("upd", {31'd0, upd}, {31'd0, upd_e});
      check("s_ready", {31'd0, s_ready}, {31'd0, (due_q.size() == 0)});
      check("an", {27'd0, an}, {27'd0, an_e});
      check("seg", {25'd0, seg}, {25'd0, exp_seg(m_prev, idx)});
    end
    p_rst  = rst;
    p_acc  = s_valid && s_ready && !rst;
    p_data = s_data;
  end

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, (n >= 100)}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input int idle);
    s_valid = 1'b1;
    s_data  = v;
    wait_accept();
    s_valid = 1'b0;
    s_data  = W'($urandom);
    repeat (idle) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!s_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", {31'd0, (n >= 200)}, 32'd0);
  endtask

  task automatic run_scan();
    repeat (2 * D * R + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_scan();

    send(W'(6), 0);
    wait_idle();
    run_scan();

    send(W'(25), 0);
    wait_idle();
    run_scan();
    send(W'(65535), 0);
    wait_idle();
    run_scan();

    // Back-pressure: valid held across two back-to-back sums.
    s_valid = 1'b1;
    s_data  = W'(10);
    wait_accept();
    s_data = W'(7);
    wait_accept();
    s_valid = 1'b0;
    wait_idle();
    run_scan();
    check("bp_spacing", acc_edges[acc_edges.size()-1] - acc_edges[acc_edges.size()-2], W + 2);

    // Reset five cycles into a conversion.
    send(W'(8), 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_scan();

    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] v;
      case ($urandom_range(0, 3))
        0:       v = W'($urandom_range(0, 9));
        1:       v = W'($urandom_range(10, 999));
        default: v = W'($urandom_range(0, 65535));
      endcase
      send(v, $urandom_range(0, 20));
    end
    wait_idle();
    run_scan();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
